s208_count_sched: RTL and testbench

Sequencer and arbiter for the shared s208-style W-bit divide counter (Y_1..Y_W register with synchronous Clear). It owns the counter and shares it between N_REQ requesters with round-robin fairness. Each granted requester supplies its own terminal count and receives a one-cycle completion pulse. The block sits between the timing clients and the divider core, which it drives through Clear and count-enable.

---
 rtl/s208_sched_pkg.sv | 22 ++
 rtl/s208_rr_arb.sv | 31 +++
 rtl/s208_count_sched.sv | 121 ++++++++++++
 tb/tb_s208_count_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s208_sched_pkg.sv
// s208_sched_pkg: shared types and helpers for the s208 count scheduler.
// Sequencer state encoding, default sizing, and a one-hot decode helper.
package s208_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam int unsigned DEF_N_REQ = 2;
    localparam int unsigned DEF_W     = 8;
    localparam int unsigned MAX_REQ   = 8;

    // One-hot decode of a requester index (wide enough for MAX_REQ)
    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/s208_rr_arb.sv
// s208_rr_arb: combinational round-robin pick.
// Returns the first requester at or after the pointer (wrapping) and a valid flag.
module s208_rr_arb
    import s208_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned PW    = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [PW-1:0]    o_win,
    output logic             o_valid
);

    logic [PW-1:0] w_idx;

    // Scan from the pointer upward, first asserted request wins
    always_comb begin
        o_win   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = PW'((32'(i_ptr) + k) % N_REQ);
            if (!o_valid && i_req[w_idx]) begin
                o_valid = 1'b1;
                o_win   = w_idx;
            end
        end
    end

endmodule

// File: rtl/s208_count_sched.sv
// s208_count_sched: round-robin sequencer owning the shared W-bit divide counter.
// Optional abort path enabled by defining S208_SCHED_ABORT_EN.
module s208_count_sched
    import s208_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned W     = DEF_W
) (
    input  logic               CK,
    input  logic               RST_N,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] tc_val,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic [W-1:0]       y,
    output logic               clear
`ifdef S208_SCHED_ABORT_EN
    ,input  logic              abort
    ,output logic              aborted
`endif
);

    localparam int unsigned PW = $clog2(N_REQ);

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [N_REQ-1:0] r_gnt;
    logic [W-1:0]     r_tc;
    logic [W-1:0]     r_y;
    logic             r_busy;
    logic             r_clear;
`ifdef S208_SCHED_ABORT_EN
    logic             r_aborted;
`endif

    logic [PW-1:0]    w_win;
    logic             w_valid;

    s208_rr_arb #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    // Sequencer: arbitration, counter control and registered outputs
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_tc      <= '0;
            r_y       <= '0;
            r_busy    <= 1'b0;
            r_clear   <= 1'b0;
`ifdef S208_SCHED_ABORT_EN
            r_aborted <= 1'b0;
`endif
        end else begin
            r_clear   <= 1'b0;
`ifdef S208_SCHED_ABORT_EN
            r_aborted <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_tc    <= tc_val[32'(w_win)*W +: W];
                        r_gnt   <= N_REQ'(onehot(3'(w_win)));
                        r_ptr   <= (32'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        r_clear <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_y     <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (r_y == r_tc) begin
                        r_state <= S_DONE;
                    end else begin
                        r_y <= r_y + 1'b1;
                    end
                end
                S_DONE: begin
                    r_gnt   <= '0;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
`ifdef S208_SCHED_ABORT_EN
            // abort overrides the LOAD/RUN transitions above; pointer keeps its advance
            if (abort && (r_state == S_LOAD || r_state == S_RUN)) begin
                r_y       <= '0;
                r_gnt     <= '0;
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
            end
`endif
        end
    end

    assign gnt   = r_gnt;
    assign done  = (r_state == S_DONE) ? r_gnt : '0;
    assign busy  = r_busy;
    assign y     = r_y;
    assign clear = r_clear;
`ifdef S208_SCHED_ABORT_EN
    assign aborted = r_aborted;
`endif

endmodule

// File: tb/tb_s208_count_sched.sv
// tb_s208_count_sched: scoreboard bench for s208_count_sched (N_REQ=2, W=8).
// Cycle labels: label L is the clock cycle that ends at rising edge L.
module tb_s208_count_sched;

    localparam int N = 2;
    localparam int W = 8;

    logic           CK     = 1'b0;
    logic           RST_N  = 1'b1;
    logic [N-1:0]   req    = '0;
    logic [N*W-1:0] tc_val = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   y;
    logic           clear;
`ifdef S208_SCHED_ABORT_EN
    logic           abort = 1'b0;
    logic           aborted;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int           lbl;
        logic [N-1:0] mask;
        logic [W-1:0] yv;
    } ev_t;

    typedef struct {
        int          lbl;
        int          sel;
        logic [31:0] val;
    } pr_t;

    ev_t gq[$];
    ev_t dq[$];
    pr_t pq[$];
    logic [N-1:0] prev_gnt = '0;

    s208_count_sched #(
        .N_REQ (N),
        .W     (W)
    ) dut (
        .CK      (CK),
        .RST_N   (RST_N),
        .req     (req),
        .tc_val  (tc_val),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .y       (y),
        .clear   (clear)
`ifdef S208_SCHED_ABORT_EN
        ,.abort  (abort)
        ,.aborted(aborted)
`endif
    );

    always #5 CK = ~CK;

    always @(posedge CK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] probe_val(input int s);
        case (s)
            0: return 32'(y);
            1: return 32'(busy);
            2: return 32'(gnt);
            3: return 32'(clear);
`ifdef S208_SCHED_ABORT_EN
            4: return 32'(aborted);
`endif
            default: return 32'hdead_beef;
        endcase
    endfunction

    function automatic string probe_name(input int s);
        case (s)
            0: return "y";
            1: return "busy";
            2: return "gnt";
            3: return "clear";
            4: return "aborted";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: pops expected grants, dones and timed probes as the DUT presents them
    always @(negedge CK) begin
        int  lbl;
        ev_t e;
        pr_t p;
        lbl = cyc + 1;
        if (!RST_N) begin
            prev_gnt = gnt;
        end else begin
            if (gnt != '0 && prev_gnt == '0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", 32'(gnt), 0);
                end else begin
                    e = gq.pop_front();
                    chk("gnt_cycle", lbl, e.lbl);
                    chk("gnt_mask", 32'(gnt), 32'(e.mask));
                end
            end
            prev_gnt = gnt;
            if (done != '0) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    e = dq.pop_front();
                    chk("done_cycle", lbl, e.lbl);
                    chk("done_mask", 32'(done), 32'(e.mask));
                    chk("done_y", 32'(y), 32'(e.yv));
                end
            end
            while (pq.size() > 0 && pq[0].lbl <= lbl) begin
                p = pq.pop_front();
                if (p.lbl < lbl)
                    chk("probe_missed", lbl, p.lbl);
                else
                    chk($sformatf("probe_%s@%0d", probe_name(p.sel), p.lbl),
                        probe_val(p.sel), p.val);
            end
        end
    end

    task automatic to_label(input int l);
        do @(negedge CK); while (cyc + 1 < l);
    endtask

    task automatic set_tc(input int i, input int v);
        tc_val[i*W +: W] = W'(v);
    endtask

    task automatic push_run(input int t0, input int idx, input int tc);
        logic [N-1:0] m;
        m = N'(1) << idx;
        gq.push_back('{lbl: t0 + 1, mask: m, yv: '0});
        dq.push_back('{lbl: t0 + 3 + tc, mask: m, yv: W'(tc)});
    endtask

    task automatic probe(input int l, input int s, input int v);
        pq.push_back('{lbl: l, sel: s, val: 32'(v)});
    endtask

    // Watchdog: every wait in the bench is bounded by this cycle budget
    initial begin
        repeat (3000) @(posedge CK);
        $display("FAIL watchdog: cycles %0d, required finish before 3000", cyc);
        $fatal(1, "watchdog expired");
    end

    // Driver: directed runs with hand-computed timing
    initial begin
        int t0;
        #1 RST_N = 1'b0;
        repeat (3) @(negedge CK);
        chk("rst_gnt",   32'(gnt),   0);
        chk("rst_done",  32'(done),  0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_y",     32'(y),     0);
        chk("rst_clear", 32'(clear), 0);
`ifdef S208_SCHED_ABORT_EN
        chk("rst_aborted", 32'(aborted), 0);
`endif
        RST_N = 1'b1;
        @(negedge CK);

        // Single request, tc=5
        set_tc(0, 5);
        req = 2'b01;
        t0  = cyc + 1;
        push_run(t0, 0, 5);
        probe(t0 + 1, 3, 1);
        probe(t0 + 2, 3, 0);
        for (int k = 0; k <= 5; k++) probe(t0 + 2 + k, 0, k);
        probe(t0 + 8, 1, 1);
        probe(t0 + 9, 1, 0);
        probe(t0 + 9, 2, 0);
        @(negedge CK);
        req = '0;
        to_label(t0 + 9);

        // tc=0 on requester 1; tc_val change after grant is ignored
        set_tc(1, 0);
        req = 2'b10;
        t0  = cyc + 1;
        push_run(t0, 1, 0);
        probe(t0 + 2, 0, 0);
        probe(t0 + 3, 0, 0);
        @(negedge CK);
        req = '0;
        set_tc(1, 7);
        to_label(t0 + 4);

        // Fairness: both held, tc=3 -> 0,1,0,1 with one IDLE gap each
        set_tc(0, 3);
        set_tc(1, 3);
        req = 2'b11;
        t0  = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            push_run(t0 + 7*k, k % 2, 3);
            probe(t0 + 7*k + 7, 2, 0);
        end
        to_label(t0 + 22);
        req = '0;
        to_label(t0 + 28);

        // Max count 255: no wrap before done
        set_tc(0, 255);
        req = 2'b01;
        t0  = cyc + 1;
        push_run(t0, 0, 255);
        probe(t0 + 256, 0, 254);
        probe(t0 + 257, 0, 255);
        probe(t0 + 258, 0, 255);
        probe(t0 + 259, 0, 255);
        @(negedge CK);
        req = '0;
        to_label(t0 + 259);

        // Reset mid-run at y=4, then requester 0 must win first
        set_tc(0, 10);
        req = 2'b01;
        t0  = cyc + 1;
        gq.push_back('{lbl: t0 + 1, mask: 2'b01, yv: '0});
        probe(t0 + 6, 0, 4);
        to_label(t0 + 6);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_gnt",  32'(gnt),  0);
        chk("midrst_y",    32'(y),    0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        dq.delete();
        pq.delete();
        req = 2'b11;
        repeat (2) @(negedge CK);
        RST_N = 1'b1;
        t0 = cyc + 1;
        push_run(t0, 0, 10);
        @(negedge CK);
        req = '0;
        to_label(t0 + 14);

`ifdef S208_SCHED_ABORT_EN
        // Abort at y=2, tc=10; pending req[1] granted after one IDLE cycle
        set_tc(0, 10);
        set_tc(1, 3);
        req = 2'b01;
        t0  = cyc + 1;
        gq.push_back('{lbl: t0 + 1, mask: 2'b01, yv: '0});
        probe(t0 + 4, 0, 2);
        @(negedge CK);
        req = '0;
        to_label(t0 + 4);
        abort = 1'b1;
        req   = 2'b10;
        probe(t0 + 5, 4, 1);
        probe(t0 + 5, 2, 0);
        probe(t0 + 5, 0, 0);
        probe(t0 + 6, 4, 0);
        push_run(t0 + 5, 1, 3);
        @(negedge CK);
        abort = 1'b0;
        @(negedge CK);
        req = '0;
        to_label(t0 + 13);
`endif

        repeat (2) @(negedge CK);
        chk("gq_empty", 32'(gq.size()), 0);
        chk("dq_empty", 32'(dq.size()), 0);
        chk("pq_empty", 32'(pq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
